// File: rtl/ad9767_cfg_pkg.sv
// Shared definitions for the AD9767 configuration register block:
// register indices, FSM state types, response code and byte-strobe merge.
package ad9767_cfg_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PHASE   = 2'd1;
  localparam logic [1:0] REG_AMPL    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_ACCEPT, W_RESP} wr_state_t;
  typedef enum logic {R_ACCEPT, R_DATA} rd_state_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ad9767_cfg_axil_slave.sv
// AXI4-Lite slave holding the AD9767 DAC configuration registers; independent
// write (AW/W/B) and read (AR/R) state machines, registered config outputs.
module ad9767_cfg_axil_slave
  import ad9767_cfg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            cfg_enable,
  output logic [1:0]                      cfg_chan_sel,
  output logic [31:0]                     cfg_phase_inc,
  output logic [15:0]                     cfg_ampl,
  output logic                            cfg_update
);

  wr_state_t   r_wr_state, w_wr_state_next;
  rd_state_t   r_rd_state, w_rd_state_next;
  logic        r_aw_held, r_w_held;
  logic [1:0]  r_aw_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_regs [4];
  logic [31:0] r_rdata;
  logic        r_cfg_update;

  logic        w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [1:0]  w_wr_idx;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_unused;

  assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT};

  assign w_aw_hs  = S_AXI_AWVALID && w_awready;
  assign w_w_hs   = S_AXI_WVALID && w_wready;
  assign w_ar_hs  = S_AXI_ARVALID && w_arready;
  // Commit once both halves are present, whether just arriving or already held.
  assign w_commit = (r_wr_state == W_ACCEPT) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_wr_idx  = w_aw_hs ? S_AXI_AWADDR[3:2] : r_aw_idx;
  assign w_wr_data = w_w_hs ? S_AXI_WDATA : r_wdata;
  assign w_wr_strb = w_w_hs ? S_AXI_WSTRB : r_wstrb;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_wr_state <= W_ACCEPT;
      r_rd_state <= R_ACCEPT;
    end else begin
      r_wr_state <= w_wr_state_next;
      r_rd_state <= w_rd_state_next;
    end
  end

  always_comb begin
    w_wr_state_next = r_wr_state;
    unique case (r_wr_state)
      W_ACCEPT: if (w_commit) w_wr_state_next = W_RESP;
      W_RESP:   if (S_AXI_BREADY) w_wr_state_next = W_ACCEPT;
    endcase
    w_rd_state_next = r_rd_state;
    unique case (r_rd_state)
      R_ACCEPT: if (w_ar_hs) w_rd_state_next = R_DATA;
      R_DATA:   if (S_AXI_RREADY) w_rd_state_next = R_ACCEPT;
    endcase
  end

  always_comb begin
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    unique case (r_wr_state)
      W_ACCEPT: begin
        w_awready = !r_aw_held;
        w_wready  = !r_w_held;
      end
      W_RESP: w_bvalid = 1'b1;
    endcase
    w_arready = (r_rd_state == R_ACCEPT);
    w_rvalid  = (r_rd_state == R_DATA);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_aw_held    <= 1'b0;
      r_w_held     <= 1'b0;
      r_aw_idx     <= 2'd0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_rdata      <= 32'd0;
      r_cfg_update <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= 32'd0;
    end else begin
      r_cfg_update <= 1'b0;
      if (w_commit) begin
        r_aw_held    <= 1'b0;
        r_w_held     <= 1'b0;
        r_regs[w_wr_idx] <= apply_wstrb(r_regs[w_wr_idx], w_wr_data, w_wr_strb);
        r_cfg_update <= (w_wr_idx != REG_SCRATCH);
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_idx  <= S_AXI_AWADDR[3:2];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= S_AXI_WDATA;
          r_wstrb  <= S_AXI_WSTRB;
        end
      end
      // Nonblocking read of r_regs yields the pre-write value on a same-edge collision.
      if (w_ar_hs) r_rdata <= r_regs[S_AXI_ARADDR[3:2]];
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = w_bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = w_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign cfg_enable    = r_regs[REG_CTRL][0];
  assign cfg_chan_sel  = r_regs[REG_CTRL][5:4];
  assign cfg_phase_inc = r_regs[REG_PHASE];
  assign cfg_ampl      = r_regs[REG_AMPL][15:0];
  assign cfg_update    = r_cfg_update;

endmodule

// File: tb/tb_ad9767_cfg_axil_slave.sv
// Self-checking bench for ad9767_cfg_axil_slave: a register model supplies
// expected read data through a queue that is popped on each R handshake.
module tb_ad9767_cfg_axil_slave;

  logic        clk = 1'b0;
  logic        S_AXI_ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        cfg_enable;
  logic [1:0]  cfg_chan_sel;
  logic [31:0] cfg_phase_inc;
  logic [15:0] cfg_ampl;
  logic        cfg_update;

  int          checks = 0;
  int          errors = 0;
  int          upd_cnt = 0;
  logic [31:0] m_regs [4];
  logic [31:0] exp_q [$];

  ad9767_cfg_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(S_AXI_ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .cfg_enable(cfg_enable), .cfg_chan_sel(cfg_chan_sel), .cfg_phase_inc(cfg_phase_inc),
    .cfg_ampl(cfg_ampl), .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (S_AXI_ARESET === 1'b0 && cfg_update === 1'b1) upd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_write(input logic [1:0] idx, input logic [31:0] data,
                             input logic [3:0] strb);
    logic [31:0] v;
    v = m_regs[idx];
    if (strb[0]) v[7:0]   = data[7:0];
    if (strb[1]) v[15:8]  = data[15:8];
    if (strb[2]) v[23:16] = data[23:16];
    if (strb[3]) v[31:24] = data[31:24];
    m_regs[idx] = v;
  endtask

  // W is presented from the first cycle, AW from cycle w_lead; B is held off b_delay cycles.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_delay);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AXI_AWVALID = !aw_done && (cyc >= w_lead);
      S_AXI_WVALID  = !w_done;
      #1;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge clk);
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      if (w_done && !aw_done) begin
        checks++;
        if (S_AXI_WREADY !== 1'b0) begin
          errors++;
          $display("FAIL wready_held: WREADY=%b required 0", S_AXI_WREADY);
        end
      end
    end
    if (!(aw_done && w_done)) begin
      errors++;
      $display("FAIL write_timeout: aw_done=%0d w_done=%0d required 1 1", aw_done, w_done);
      return;
    end
    model_write(addr[3:2], data, strb);
    checks++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
      errors++;
      $display("FAIL bvalid_latency: BVALID=%b BRESP=%b required 1 00", S_AXI_BVALID,
               S_AXI_BRESP);
    end
    for (int i = 0; i < b_delay; i++) begin
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
        errors++;
        $display("FAIL b_backpressure: BVALID=%b AWREADY=%b WREADY=%b required 1 0 0",
                 S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
      end
      @(negedge clk);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    checks++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
      errors++;
      $display("FAIL b_done: BVALID=%b AWREADY=%b WREADY=%b required 0 1 1", S_AXI_BVALID,
               S_AXI_AWREADY, S_AXI_WREADY);
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_delay);
    bit hs;
    int cyc;
    logic [31:0] held, exp_v;
    hs = 0; cyc = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    exp_q.push_back(m_regs[addr[3:2]]);
    while (!hs && cyc < 50) begin
      #1;
      hs = S_AXI_ARREADY;
      @(negedge clk);
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    checks++;
    if (!hs || S_AXI_RVALID !== 1'b1) begin
      errors++;
      $display("FAIL read_latency: hs=%0d RVALID=%b required 1 1", hs, S_AXI_RVALID);
      void'(exp_q.pop_front());
      return;
    end
    held = S_AXI_RDATA;
    for (int i = 0; i < r_delay; i++) begin
      @(negedge clk);
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== held) begin
        errors++;
        $display("FAIL r_stable: RVALID=%b RDATA=%h required 1 %h", S_AXI_RVALID,
                 S_AXI_RDATA, held);
      end
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (S_AXI_RDATA !== exp_v || S_AXI_RRESP !== 2'b00) begin
      errors++;
      $display("FAIL rdata_%h: RDATA=%h RRESP=%b required %h 00", addr, S_AXI_RDATA,
               S_AXI_RRESP, exp_v);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge clk);
    S_AXI_RREADY = 1'b0;
    checks++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL r_done: RVALID=%b ARREADY=%b required 0 1", S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11100
        || S_AXI_RDATA !== 32'd0 || cfg_enable !== 1'b0 || cfg_chan_sel !== 2'd0
        || cfg_phase_inc !== 32'd0 || cfg_ampl !== 16'd0 || cfg_update !== 1'b0) begin
      errors++;
      $display("FAIL %s: rdy/valid=%b rdata=%h cfg=%b %b %h %h %b required 11100 0 all 0",
               name, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
               S_AXI_RVALID}, S_AXI_RDATA, cfg_enable, cfg_chan_sel, cfg_phase_inc,
               cfg_ampl, cfg_update);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 32'd0;
    S_AXI_ARESET = 1'b1;
    repeat (3) @(negedge clk);
    S_AXI_ARESET = 1'b0;
    check_idle("reset_state");
  endtask

  task automatic test_basic();
    int u;
    for (int i = 0; i < 4; i++) begin
      u = upd_cnt;
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
      checks++;
      if (upd_cnt - u !== ((i == 3) ? 0 : 1)) begin
        errors++;
        $display("FAIL update_count_reg%0d: pulses=%0d required %0d", i, upd_cnt - u,
                 (i == 3) ? 0 : 1);
      end
    end
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
    checks++;
    if (cfg_enable !== 1'b1 || cfg_phase_inc !== 32'd2 || cfg_ampl !== 16'd3) begin
      errors++;
      $display("FAIL cfg_basic: en=%b phase=%h ampl=%h required 1 00000002 0003", cfg_enable,
               cfg_phase_inc, cfg_ampl);
    end
  endtask

  task automatic test_w_before_aw();
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, 3, 0);
    checks++;
    if (cfg_phase_inc !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL phase_w_first: cfg_phase_inc=%h required deadbeef", cfg_phase_inc);
    end
    axi_read(4'h4, 0);
  endtask

  task automatic test_wstrb();
    int u;
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0);
    u = upd_cnt;
    axi_write(4'h4, 32'h12345678, 4'b0101, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (upd_cnt - u !== 1 || cfg_phase_inc !== 32'hFF34FF78) begin
      errors++;
      $display("FAIL wstrb_merge: pulses=%0d phase=%h required 1 ff34ff78", upd_cnt - u,
               cfg_phase_inc);
    end
    axi_read(4'h4, 0);
  endtask

  task automatic test_backpressure();
    axi_write(4'h8, 32'h0000_0055, 4'hF, 0, 10);
    axi_write(4'hC, 32'hCAFE_F00D, 4'hF, 0, 0);
    axi_read(4'hC, 6);
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_v;
    axi_write(4'h8, 32'd3, 4'hF, 0, 0);
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0000_AAAA; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    exp_q.push_back(m_regs[2]);
    @(negedge clk);
    S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    model_write(2'd2, 32'h0000_AAAA, 4'hF);
    exp_v = exp_q.pop_front();
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_BVALID !== 1'b1 || S_AXI_RDATA !== exp_v) begin
      errors++;
      $display("FAIL same_cycle_rw: RVALID=%b BVALID=%b RDATA=%h required 1 1 %h",
               S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA, exp_v);
    end
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    axi_read(4'h8, 0);
    checks++;
    if (cfg_ampl !== 16'hAAAA) begin
      errors++;
      $display("FAIL ampl_after_collision: cfg_ampl=%h required aaaa", cfg_ampl);
    end
  endtask

  task automatic test_reset_mid();
    axi_write(4'h0, 32'h0000_0031, 4'hF, 0, 0);
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h1111_2222; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge clk);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1 || cfg_chan_sel !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_pending: BVALID=%b RVALID=%b chan=%b required 1 1 11",
               S_AXI_BVALID, S_AXI_RVALID, cfg_chan_sel);
    end
    S_AXI_ARESET = 1'b1;
    @(negedge clk);
    S_AXI_ARESET = 1'b0;
    check_idle("reset_mid_txn");
    for (int i = 0; i < 4; i++) m_regs[i] = 32'd0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
    axi_write(4'h0, 32'h0000_0011, 4'hF, 0, 0);
    checks++;
    if (cfg_enable !== 1'b1 || cfg_chan_sel !== 2'b01) begin
      errors++;
      $display("FAIL write_after_reset: en=%b chan=%b required 1 01", cfg_enable, cfg_chan_sel);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_w_before_aw();
    test_wstrb();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
